spu_arbiter: RTL and testbench

//  Shares one sigmoid processing unit (SPU: combinational float32 -> float32 sigmoid)

---
 rtl/spu_arbiter.sv | 110 +++++++++++
 tb/tb_spu_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spu_arbiter.sv
// Round-robin arbiter sharing one sigmoid unit between N_REQ requesters.
// Two registered stages: issue reg drives spu_x, result reg captures spu_y.
module spu_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*32-1:0]        req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [31:0]                spu_x,
    input  logic [31:0]                spu_y,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_data,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);

    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_x_q, s1_x_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            adv1, adv2;
    logic            found;
    logic            take;
    logic [ID_W-1:0] gnt_id;
    logic [N_REQ-1:0] gnt;
    int              idx;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        adv2   = !rsp_valid_q | rsp_ready;
        adv1   = !s1_valid_q | adv2;
        found  = 1'b0;
        gnt_id = '0;
        gnt    = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
        take = adv1 & found & !reset;
        if (take) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (adv1) begin
            s1_valid_d = take;
            if (take) begin
                s1_x_d   = req_data[32*int'(gnt_id) +: 32];
                s1_id_d  = gnt_id;
                rr_ptr_d = ID_W'((int'(gnt_id) + 1) % N_REQ);
            end
        end
        if (adv2) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_data_d = spu_y;
                rsp_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign req_ready = gnt;
    assign spu_x     = s1_x_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_spu_arbiter.sv
// Bench for spu_arbiter: directed vector table, then random traffic
// checked against a queue-based model of accepted operands.
module tb_spu_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [31:0]     dat [N];
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [31:0]     spu_x;
    logic [31:0]     spu_y;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic            busy;

    always #5 clk = ~clk;

    // Stand-in for the sigmoid unit: cheap bijection with f(0)=0x3F000000.
    function automatic logic [31:0] spu_f(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h3F00_0000;
    endfunction

    assign spu_y    = spu_f(spu_x);
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    spu_arbiter #(.N_REQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .spu_x    (spu_x),
        .spu_y    (spu_y),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [31:0] d;
        int          a;
    } item_t;

    item_t      q[$];
    int         rr;
    int         cyc;
    int         wt [N];
    logic [N-1:0] last_gnt;

    // Model: accepted operand reaches the output one edge after its accept
    // edge once it is oldest; a new grant is possible unless two are in flight
    // and the consumer is stalling.
    task automatic check_model();
        logic [N-1:0] er;
        logic         erv;
        int           gi;
        item_t        it;
        erv = (q.size() > 0) && (cyc >= q[0].a + 1);
        er  = '0;
        gi  = -1;
        if (!reset && (q.size() < 2 || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr + k) % N;
                if (gi < 0 && req_valid[j]) gi = j;
            end
        end
        if (gi >= 0) er[gi] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(erv));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (erv) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_data", rsp_data, spu_f(q[0].d));
        end
        if (req_ready != '0 && !reset) begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) wt[i] = 0;
                else if (req_valid[i]) wt[i]++;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) chk("starvation", 32'(wt[i] < N), 32'd1);
            end
        end
        last_gnt = er;
        if (reset) begin
            q.delete();
            rr = 0;
            for (int i = 0; i < N; i++) wt[i] = 0;
        end else begin
            if (erv && rsp_ready) void'(q.pop_front());
            if (gi >= 0) begin
                it.id = 2'(gi);
                it.d  = dat[gi];
                it.a  = cyc + 1;
                q.push_back(it);
                rr = (gi + 1) % N;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rr;
        logic [3:0] rdy;
        logic       rv;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t tbl [34];

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1};
        tbl[7]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1};
        tbl[8]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0};
        tbl[11] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 1'b1};
        tbl[12] = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd0, 1'b1};
        tbl[13] = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd1, 1'b1};
        tbl[14] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd2, 1'b1};
        tbl[15] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1};
        tbl[16] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1};
        tbl[17] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 4'hF, 1'b0, 4'h2, 1'b0, 2'd0, 1'b0};
        tbl[19] = '{1'b0, 4'hF, 1'b0, 4'h4, 1'b0, 2'd0, 1'b1};
        tbl[20] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1};
        tbl[21] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1};
        tbl[22] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1};
        tbl[23] = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd1, 1'b1};
        tbl[24] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1};
        tbl[25] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1};
        tbl[26] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[27] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0};
        tbl[28] = '{1'b1, 4'hA, 1'b1, 4'h0, 1'b0, 2'd0, 1'b1};
        tbl[29] = '{1'b0, 4'hA, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0};
        tbl[30] = '{1'b0, 4'h8, 1'b1, 4'h8, 1'b0, 2'd0, 1'b1};
        tbl[31] = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1};
        tbl[32] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
        tbl[33] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};

        dat[0] = 32'h4049_0FDB;
        dat[1] = 32'hBF80_0000;
        dat[2] = 32'h0000_0000;
        dat[3] = 32'h7FC0_0000;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        rr        = 0;
        cyc       = 0;
        last_gnt  = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;
        tick();

        for (int r = 0; r < 34; r++) begin
            reset     = tbl[r].rst;
            req_valid = tbl[r].v;
            rsp_ready = tbl[r].rr;
            @(negedge clk);
            chk($sformatf("vec%0d.ready", r), 32'(req_ready), 32'(tbl[r].rdy));
            chk($sformatf("vec%0d.rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rv));
            chk($sformatf("vec%0d.busy", r), 32'(busy), 32'(tbl[r].busy));
            if (tbl[r].rv) begin
                chk($sformatf("vec%0d.rsp_id", r), 32'(rsp_id), 32'(tbl[r].id));
                chk($sformatf("vec%0d.rsp_data", r), rsp_data, spu_f(dat[tbl[r].id]));
            end
            if (r < 2) chk($sformatf("vec%0d.spu_x", r), spu_x, 32'h0);
            check_model();
            tick();
        end

        reset     = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check_model();
            tick();
            reset     = ($urandom_range(0, 249) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_gnt[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    dat[i]       = $urandom;
                end
            end
        end

        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_model();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
